wb_shared_bus: RTL and testbench
================================

# wb_shared_bus

Parametrised single-master Wishbone shared-bus interconnect. It connects the control unit, as master, to N slave peripherals (UART, frequency counter, future blocks). It replaces wired-OR merging of slave outputs with registered address decode and a per-slave response mux. It adds a watchdog that terminates unanswered cycles with an error and decode-miss error generation, and keeps saturating error statistics for debug LEDs and register readback.

## Interface
Parameters:
- N_SLAVES, 4: number of slave ports (1..8)
- ADDR_W, 32: address width
- DATA_W, 32: data width; SEL_W = DATA_W/8
- SLAVE_BASE, {N_SLAVES{32'h0}}: packed N_SLAVES*ADDR_W base addresses, slave 0 in LSBs
- SLAVE_MASK, {N_SLAVES{32'hFFFF_0000}}: packed decode masks; hit when (addr & mask) == base
- TIMEOUT_CYCLES, 255: ACTIVE cycles without response before forced error (1..65535)

Ports:
- clk_i  in  1  system clock, sole clock domain
- rst_i  in  1  asynchronous, active-high reset
- m_addr_i / m_dat_i / m_sel_i / m_we_i  in  ADDR_W / DATA_W / SEL_W / 1  master request
- m_cyc_i, m_stb_i, m_lock_i  in  1 each  master cycle, strobe, lock
- m_dat_o  out  DATA_W  read data of the selected slave
- m_ack_o, m_err_o, m_rty_o  out  1 each  terminations to master
- s_addr_o / s_dat_o / s_sel_o / s_we_o / s_lock_o  out  broadcast copies of master signals
- s_cyc_o, s_stb_o  out  N_SLAVES  per-slave cycle/strobe, one-hot or zero
- s_dat_i  in  N_SLAVES*DATA_W  packed slave read data
- s_ack_i, s_err_i, s_rty_i  in  N_SLAVES  per-slave terminations
- err_count_o  out  16  saturating count of decode and timeout errors
- last_err_addr_o  out  ADDR_W  address of most recent bus error
- busy_o  out  1  high when state != IDLE

## Operation
- FSM states: IDLE, ACTIVE, DERR, TOUT.
- IDLE: when m_cyc_i & m_stb_i, decode m_addr_i. If any slave hits, the lowest index wins; register the one-hot select; go to ACTIVE. On a miss, latch the address and go to DERR.
- ACTIVE: s_cyc_o[sel] = m_cyc_i; s_stb_o[sel] = m_stb_i. Terminations from the selected slave pass combinationally to the master. Priority err > rty > ack; only one of m_ack_o/m_err_o/m_rty_o is high. Non-selected slaves' responses and data are ignored.
- ACTIVE exit: on any selected-slave termination, return to IDLE. If m_cyc_i drops without a termination, return to IDLE silently. On a watchdog match, go to TOUT.
- Locked cycles: while m_lock_i & m_cyc_i, the selection is held after a termination. Next strobes go to the same slave without re-decode; the FSM stays in ACTIVE.
- DERR / TOUT: drive m_err_o = 1 for exactly one cycle with s_cyc_o = s_stb_o = 0. Increment err_count_o (saturate at 16'hFFFF). Latch last_err_addr_o. Then go to IDLE.
- Watchdog: 16-bit counter, cleared on entering ACTIVE and on each termination; increments every ACTIVE cycle with m_stb_i high. Reaching TIMEOUT_CYCLES triggers TOUT.
- m_dat_o = s_dat_i slice of the registered select in ACTIVE; 0 otherwise.

## Timing
- Reset values: state IDLE, select 0, all s_cyc_o/s_stb_o 0, m_ack_o/m_err_o/m_rty_o 0, m_dat_o 0, err_count_o 0, last_err_addr_o 0, busy_o 0.
- Decode costs one cycle: a request at cycle 0 gives s_stb_o from cycle 1. A zero-wait slave acks in cycle 1, and m_ack_o is high in cycle 1.
- A non-locked back-to-back transfer re-enters IDLE for one cycle, so the minimum is 2 cycles per transfer.
- A decode miss at cycle 0 gives m_err_o high in cycle 1 only.
- Timeout gives m_err_o in cycle TIMEOUT_CYCLES+2 after the request.
- Reset mid-cycle forces IDLE immediately and aborts the slave cycle. No termination is sent to the master.
- A slave ack arriving in the same cycle the watchdog matches is a termination, so the ack is delivered and there is no TOUT.

## Structure
- Package wb_bus_pkg: state encoding localparams, Wishbone width constants, shared decode function (addr, base, mask → hit).
- Sub-module wb_bus_watchdog: counter, clear, enable, and match output. The FSM, decode, and mux stay in wb_shared_bus.

## Test plan
- Write 32'hDEADBEEF to 0x0001_0004 with slave 1 base 0x0001_0000 and zero-wait ack → s_stb_o = 4'b0010 in cycle 1, m_ack_o in cycle 1, s_dat_o = 32'hDEADBEEF.
- Read 0x0002_0000 with slave 2 returning 32'h1234_5678 after 3 waits, and slave 0 driving ack and data concurrently → m_dat_o = 32'h1234_5678 and a single m_ack_o, at slave 2's ack only.
- Access 0x00F0_0000 (no hit) → m_err_o one cycle in cycle 1, no s_cyc_o, err_count_o = 1, last_err_addr_o = 0x00F0_0000.
- TIMEOUT_CYCLES = 8 with a silent slave → m_err_o in cycle 10, s_cyc_o drops, err_count_o increments; simultaneous ack at the match cycle → ack delivered, no error.
- Locked 3-read burst to slave 3 → no IDLE gaps, s_cyc_o[3] held through all; assert rst_i mid-burst → all outputs to reset values the same cycle.
- Force err_count_o to 16'hFFFF via 65535 misses, then one more → stays 16'hFFFF.

Source files
------------

// File: rtl/wb_bus_pkg.sv
// Shared types and helpers for the Wishbone shared-bus interconnect:
// FSM state encoding, counter widths, address decode and saturating increment.
package wb_bus_pkg;

  localparam int WB_CNT_W  = 16;
  localparam int WB_MAX_AW = 64;
  localparam logic [WB_CNT_W-1:0] WB_CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DERR   = 2'd2,
    ST_TOUT   = 2'd3
  } wb_state_e;

  function automatic logic wb_decode_hit(input logic [WB_MAX_AW-1:0] addr,
                                         input logic [WB_MAX_AW-1:0] base,
                                         input logic [WB_MAX_AW-1:0] mask);
    return ((addr & mask) == base);
  endfunction

  function automatic logic [WB_CNT_W-1:0] wb_sat_inc(input logic [WB_CNT_W-1:0] v);
    return (v == WB_CNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/wb_bus_watchdog.sv
// Bus-cycle watchdog: counts enabled cycles since the last clear and flags
// when the count reaches the configured limit.
module wb_bus_watchdog
  import wb_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic match_o
);

  localparam logic [WB_CNT_W-1:0] LIMIT = WB_CNT_W'(TIMEOUT_CYCLES);

  logic [WB_CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins over enable.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = wb_sat_inc(cnt_q);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_o = (cnt_q == LIMIT);

endmodule

// File: rtl/wb_shared_bus.sv
// Single-master Wishbone shared bus: registered address decode, per-slave response
// mux, decode-miss and watchdog error terminations, saturating error statistics.
module wb_shared_bus
  import wb_bus_pkg::*;
#(
  parameter int N_SLAVES = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_BASE = {N_SLAVES{32'h0000_0000}},
  parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_MASK = {N_SLAVES{32'hFFFF_0000}},
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [ADDR_W-1:0]          m_addr_i,
  input  logic [DATA_W-1:0]          m_dat_i,
  input  logic [DATA_W/8-1:0]        m_sel_i,
  input  logic                       m_we_i,
  input  logic                       m_cyc_i,
  input  logic                       m_stb_i,
  input  logic                       m_lock_i,
  output logic [DATA_W-1:0]          m_dat_o,
  output logic                       m_ack_o,
  output logic                       m_err_o,
  output logic                       m_rty_o,
  output logic [ADDR_W-1:0]          s_addr_o,
  output logic [DATA_W-1:0]          s_dat_o,
  output logic [DATA_W/8-1:0]        s_sel_o,
  output logic                       s_we_o,
  output logic                       s_lock_o,
  output logic [N_SLAVES-1:0]        s_cyc_o,
  output logic [N_SLAVES-1:0]        s_stb_o,
  input  logic [N_SLAVES*DATA_W-1:0] s_dat_i,
  input  logic [N_SLAVES-1:0]        s_ack_i,
  input  logic [N_SLAVES-1:0]        s_err_i,
  input  logic [N_SLAVES-1:0]        s_rty_i,
  output logic [15:0]                err_count_o,
  output logic [ADDR_W-1:0]          last_err_addr_o,
  output logic                       busy_o
);

  wb_state_e             state_q, state_d;
  logic [N_SLAVES-1:0]   sel_q, sel_d, hit_vec, dec_sel;
  logic [WB_CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0]     last_err_addr_q, last_err_addr_d;
  logic [DATA_W-1:0]     mux_dat;
  logic [WB_MAX_AW-1:0]  addr_ext, base_ext, mask_ext;
  logic                  sel_ack, sel_err, sel_rty, term;
  logic                  wd_clr, wd_en, wd_match;

  assign s_addr_o = m_addr_i;
  assign s_dat_o  = m_dat_i;
  assign s_sel_o  = m_sel_i;
  assign s_we_o   = m_we_i;
  assign s_lock_o = m_lock_i;

  // Address decode; the descending scan leaves the lowest-index hit selected.
  always_comb begin
    hit_vec  = '0;
    dec_sel  = '0;
    addr_ext = '0;
    base_ext = '0;
    mask_ext = '0;
    addr_ext[ADDR_W-1:0] = m_addr_i;
    for (int i = 0; i < N_SLAVES; i++) begin
      base_ext[ADDR_W-1:0] = SLAVE_BASE[i*ADDR_W +: ADDR_W];
      mask_ext[ADDR_W-1:0] = SLAVE_MASK[i*ADDR_W +: ADDR_W];
      hit_vec[i] = wb_decode_hit(addr_ext, base_ext, mask_ext);
    end
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        dec_sel    = '0;
        dec_sel[i] = 1'b1;
      end else begin
        dec_sel = dec_sel;
      end
    end
  end

  // Read-data mux over the registered select only.
  always_comb begin
    mux_dat = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (sel_q[i]) begin
        mux_dat = mux_dat | s_dat_i[i*DATA_W +: DATA_W];
      end else begin
        mux_dat = mux_dat;
      end
    end
  end

  assign sel_ack = |(s_ack_i & sel_q);
  assign sel_err = |(s_err_i & sel_q);
  assign sel_rty = |(s_rty_i & sel_q);
  assign term    = (state_q == ST_ACTIVE) && m_cyc_i && m_stb_i && (sel_ack || sel_err || sel_rty);
  assign m_dat_o = (state_q == ST_ACTIVE) ? mux_dat : '0;

  assign wd_clr = (state_q != ST_ACTIVE) || term;
  assign wd_en  = (state_q == ST_ACTIVE) && m_stb_i;

  wb_bus_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (wd_clr),
    .en_i    (wd_en),
    .match_o (wd_match)
  );

  // Next state, select, statistics and bus outputs; statistics update on error entry.
  always_comb begin
    state_d         = state_q;
    sel_d           = sel_q;
    err_cnt_d       = err_cnt_q;
    last_err_addr_d = last_err_addr_q;
    m_ack_o         = 1'b0;
    m_err_o         = 1'b0;
    m_rty_o         = 1'b0;
    s_cyc_o         = '0;
    s_stb_o         = '0;
    case (state_q)
      ST_IDLE: begin
        sel_d = '0;
        if (m_cyc_i && m_stb_i) begin
          if (|hit_vec) begin
            state_d = ST_ACTIVE;
            sel_d   = dec_sel;
          end else begin
            state_d         = ST_DERR;
            err_cnt_d       = wb_sat_inc(err_cnt_q);
            last_err_addr_d = m_addr_i;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        s_cyc_o = sel_q & {N_SLAVES{m_cyc_i}};
        s_stb_o = sel_q & {N_SLAVES{m_stb_i}};
        if (term) begin
          m_err_o = sel_err;
          m_rty_o = !sel_err && sel_rty;
          m_ack_o = !sel_err && !sel_rty && sel_ack;
        end else begin
          m_err_o = 1'b0;
        end
        if (!m_cyc_i) begin
          state_d = ST_IDLE;
          sel_d   = '0;
        end else if (term) begin
          if (m_lock_i) begin
            state_d = ST_ACTIVE;
          end else begin
            state_d = ST_IDLE;
            sel_d   = '0;
          end
        end else if (wd_match) begin
          state_d         = ST_TOUT;
          sel_d           = '0;
          err_cnt_d       = wb_sat_inc(err_cnt_q);
          last_err_addr_d = m_addr_i;
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      ST_DERR, ST_TOUT: begin
        m_err_o = 1'b1;
        state_d = ST_IDLE;
        sel_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = '0;
      end
    endcase
  end

  // State, select and statistics registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= ST_IDLE;
      sel_q           <= '0;
      err_cnt_q       <= '0;
      last_err_addr_q <= '0;
    end else begin
      state_q         <= state_d;
      sel_q           <= sel_d;
      err_cnt_q       <= err_cnt_d;
      last_err_addr_q <= last_err_addr_d;
    end
  end

  assign err_count_o     = err_cnt_q;
  assign last_err_addr_o = last_err_addr_q;
  assign busy_o          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_wb_shared_bus.sv
// Self-checking bench for wb_shared_bus: directed and random transactions
// against a transaction-level reference model, plus lock, reset and saturation.
module tb_wb_shared_bus;

  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;
  localparam logic [NS*AW-1:0] BASES = {32'h0003_0000, 32'h0002_0000, 32'h0001_0000, 32'h0000_0000};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0]    m_addr_i = '0;
  logic [DW-1:0]    m_dat_i = '0;
  logic [DW/8-1:0]  m_sel_i = '0;
  logic             m_we_i = 1'b0, m_cyc_i = 1'b0, m_stb_i = 1'b0, m_lock_i = 1'b0;
  logic [DW-1:0]    m_dat_o;
  logic             m_ack_o, m_err_o, m_rty_o;
  logic [AW-1:0]    s_addr_o;
  logic [DW-1:0]    s_dat_o;
  logic [DW/8-1:0]  s_sel_o;
  logic             s_we_o, s_lock_o;
  logic [NS-1:0]    s_cyc_o, s_stb_o;
  logic [NS*DW-1:0] s_dat_i;
  logic [NS-1:0]    s_ack_i, s_err_i, s_rty_i;
  logic [15:0]      err_count_o;
  logic [AW-1:0]    last_err_addr_o;
  logic             busy_o;

  wb_shared_bus #(
    .N_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW),
    .SLAVE_BASE(BASES), .SLAVE_MASK({NS{32'hFFFF_0000}}), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .m_addr_i(m_addr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_lock_i(m_lock_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .s_addr_o(s_addr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_lock_o(s_lock_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .err_count_o(err_count_o), .last_err_addr_o(last_err_addr_o), .busy_o(busy_o)
  );

  // Slave behaviour: kind 0 ack, 1 err, 2 rty, 3 silent; answers after slv_wait strobed cycles.
  int          slv_wait[NS];
  int          slv_kind[NS];
  logic [31:0] slv_rdata[NS];
  int          slv_cnt[NS];
  logic [NS-1:0] slv_resp;
  bit          rogue = 1'b0;

  always_comb begin
    s_ack_i = '0; s_err_i = '0; s_rty_i = '0; s_dat_i = '0; slv_resp = '0;
    for (int i = 0; i < NS; i++) begin
      slv_resp[i] = s_cyc_o[i] && s_stb_o[i] && (slv_kind[i] != 3) && (slv_cnt[i] == slv_wait[i]);
      s_ack_i[i]  = slv_resp[i] && (slv_kind[i] == 0);
      s_err_i[i]  = slv_resp[i] && (slv_kind[i] == 1);
      s_rty_i[i]  = slv_resp[i] && (slv_kind[i] == 2);
      s_dat_i[i*DW +: DW] = slv_rdata[i];
    end
    if (rogue) begin
      s_ack_i[0]      = 1'b1;
      s_dat_i[DW-1:0] = 32'hBAD0_BAD0;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NS; i++) begin
      if (rst || !s_stb_o[i] || slv_resp[i]) slv_cnt[i] <= 0;
      else slv_cnt[i] <= slv_cnt[i] + 1;
    end
  end

  int n_checks = 0;
  int n_fail = 0;
  logic [15:0] ref_cnt = 16'h0000;
  logic [31:0] ref_last = 32'h0000_0000;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Address map: slave i owns 0x000i_xxxx.
  function automatic int ref_target(input logic [31:0] a);
    if (int'(a[31:16]) < NS) return int'(a[31:16]);
    return -1;
  endfunction

  task automatic ref_error(input logic [31:0] a);
    if (ref_cnt != 16'hFFFF) ref_cnt = ref_cnt + 16'd1;
    ref_last = a;
  endtask

  task automatic check_stats(input string tag);
    check_eq({tag, "/errcnt"}, err_count_o, ref_cnt);
    check_eq({tag, "/lastaddr"}, last_err_addr_o, ref_last);
  endtask

  task automatic run_txn(input string tag, input logic [31:0] addr, input logic we, input logic [31:0] wdata);
    int tgt, exp_cyc, got_cyc;
    logic [2:0] exp_term, got_term;
    logic [NS-1:0] exp_sel, got_sel;
    logic [31:0] got_dat;
    bit is_err;
    tgt = ref_target(addr);
    is_err = 1'b0;
    got_term = 3'b000; got_sel = '0; got_dat = '0;
    if (tgt < 0) begin
      exp_cyc = 1; exp_term = 3'b100; exp_sel = '0; is_err = 1'b1;
    end else if (slv_kind[tgt] == 3 || slv_wait[tgt] > TO) begin
      exp_cyc = TO + 2; exp_term = 3'b100; exp_sel = '0; is_err = 1'b1;
    end else begin
      exp_cyc = 1 + slv_wait[tgt];
      exp_sel = NS'(1) << tgt;
      exp_term = (slv_kind[tgt] == 0) ? 3'b001 : (slv_kind[tgt] == 1) ? 3'b100 : 3'b010;
    end
    @(negedge clk);
    m_addr_i = addr; m_we_i = we; m_dat_i = wdata; m_sel_i = 4'hF;
    m_lock_i = 1'b0; m_cyc_i = 1'b1; m_stb_i = 1'b1;
    got_cyc = -1;
    for (int c = 1; c <= TO + 6; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        check_eq({tag, "/stb_c1"}, s_stb_o, (tgt < 0) ? 64'd0 : (64'd1 << tgt));
        if (we) check_eq({tag, "/wdat"}, {s_we_o, s_dat_o}, {1'b1, wdata});
      end
      if (m_ack_o || m_err_o || m_rty_o) begin
        got_cyc = c; got_term = {m_err_o, m_rty_o, m_ack_o};
        got_sel = s_cyc_o; got_dat = m_dat_o;
        break;
      end
    end
    if (is_err) ref_error(addr);
    check_eq({tag, "/term_cycle"}, got_cyc, exp_cyc);
    check_eq({tag, "/term_kind"}, got_term, exp_term);
    check_eq({tag, "/cyc_at_term"}, got_sel, exp_sel);
    if (!we && exp_term == 3'b001 && tgt >= 0) check_eq({tag, "/rdata"}, got_dat, slv_rdata[tgt]);
    check_stats(tag);
    @(posedge clk); #1;
    m_cyc_i = 1'b0; m_stb_i = 1'b0;
    check_eq({tag, "/after"}, {busy_o, m_err_o, m_rty_o, m_ack_o, m_dat_o}, 36'd0);
  endtask

  task automatic cfg(input int s, input int k, input int w, input logic [31:0] d);
    slv_kind[s] = k; slv_wait[s] = w; slv_rdata[s] = d;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    for (int i = 0; i < NS; i++) cfg(i, 0, 0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outputs", {s_cyc_o, s_stb_o, m_ack_o, m_err_o, m_rty_o, m_dat_o, busy_o}, 44'd0);
    check_stats("reset");
    @(negedge clk); rst = 1'b0;

    cfg(1, 0, 0, 32'h0);
    run_txn("wr_slave1", 32'h0001_0004, 1'b1, 32'hDEAD_BEEF);
    cfg(2, 0, 3, 32'h1234_5678); rogue = 1'b1;
    run_txn("rd_slave2_rogue0", 32'h0002_0000, 1'b0, 32'h0);
    rogue = 1'b0;
    run_txn("decode_miss", 32'h00F0_0000, 1'b0, 32'h0);
    cfg(1, 3, 0, 32'h0);
    run_txn("timeout", 32'h0001_0040, 1'b0, 32'h0);
    cfg(2, 0, TO, 32'hA5A5_0F0F);
    run_txn("ack_at_match", 32'h0002_0008, 1'b0, 32'h0);
    cfg(3, 1, 2, 32'h0);
    run_txn("slave_err", 32'h0003_0000, 1'b0, 32'h0);
    cfg(0, 2, 1, 32'h0);
    run_txn("slave_rty", 32'h0000_0010, 1'b1, 32'h0BAD_F00D);

    for (int n = 0; n < 80; n++) begin
      for (int i = 0; i < NS; i++) begin
        int r;
        r = $urandom_range(0, 9);
        cfg(i, (r < 6) ? 0 : (r == 6) ? 1 : (r == 7) ? 2 : 3, $urandom_range(0, TO + 2), $urandom);
      end
      if ($urandom_range(0, 4) == 4) a = {16'($urandom_range(NS, 65535)), 16'($urandom)};
      else a = {16'($urandom_range(0, NS - 1)), 16'($urandom)};
      rogue = (a[31:16] != 16'h0) && ($urandom_range(0, 1) == 1);
      run_txn("random", a, 1'($urandom_range(0, 1)), $urandom);
    end
    rogue = 1'b0;

    cfg(3, 0, 1, 32'hC0DE_0003);
    @(negedge clk);
    m_addr_i = 32'h0003_0010; m_we_i = 1'b0; m_lock_i = 1'b1; m_cyc_i = 1'b1; m_stb_i = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      check_eq("lock/cyc", {busy_o, s_cyc_o}, 5'b1_1000);
      check_eq("lock/ack", m_ack_o, (c % 2 == 0));
      if (c % 2 == 0) check_eq("lock/rdata", m_dat_o, 32'hC0DE_0003);
    end
    m_cyc_i = 1'b0; m_stb_i = 1'b0; m_lock_i = 1'b0;
    @(posedge clk); #1;
    check_eq("lock/end_idle", {busy_o, s_cyc_o}, 5'd0);

    @(negedge clk);
    m_addr_i = 32'h0003_0020; m_lock_i = 1'b1; m_cyc_i = 1'b1; m_stb_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_burst/ack_before", m_ack_o, 1'b1);
    rst = 1'b1; #1;
    ref_cnt = 16'h0000; ref_last = 32'h0;
    check_eq("rst_burst/outputs", {s_cyc_o, s_stb_o, m_ack_o, m_err_o, m_rty_o, m_dat_o, busy_o}, 44'd0);
    check_stats("rst_burst");
    @(negedge clk);
    m_cyc_i = 1'b0; m_stb_i = 1'b0; m_lock_i = 1'b0; rst = 1'b0;

    @(negedge clk);
    force dut.err_cnt_q = 16'hFFFE;
    #1 release dut.err_cnt_q;
    ref_cnt = 16'hFFFE;
    run_txn("sat_miss1", 32'h0100_0000, 1'b0, 32'h0);
    run_txn("sat_miss2", 32'h0200_0004, 1'b0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
